// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between the fetch unit and memory.
//   imem_req    fetch -> mem  request valid (at most one outstanding)
//   imem_addr   fetch -> mem  word-aligned request address
//   imem_gnt    mem -> fetch  request accepted this cycle
//   imem_rvalid mem -> fetch  response data valid
//   imem_rdata  mem -> fetch  instruction word
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with a one-entry skid buffer and redirect flush.
//   clk               clock, rising edge
//   rst               asynchronous active-high reset
//   stall_i           IF/ID hold; presented instruction must not change while held
//   redirect_valid_i  taken branch/jump; flushes fetch, highest priority
//   redirect_pc_i     new fetch address ([1:0] ignored)
//   imem              instruction-memory bus (master side)
//   if_valid_o        instruction presented to IF/ID
//   if_pc_o           address of presented instruction
//   if_instr_o        presented instruction
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    fetch_unit_if.master imem,
    output logic         if_valid_o,
    output logic [31:0]  if_pc_o,
    output logic [31:0]  if_instr_o
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic        drop_q, drop_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d, if_instr_q, if_instr_d;
    logic [31:0] redirect_pc;
    logic        slot_free;

    assign redirect_pc    = {redirect_pc_i[31:2], 2'b00};
    assign slot_free      = !if_valid_q || !stall_i;
    assign imem.imem_req  = state_q == S_REQ;
    assign imem.imem_addr = {pc_q[31:2], 2'b00};
    assign if_valid_o     = if_valid_q;
    assign if_pc_o        = if_pc_q;
    assign if_instr_o     = if_instr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        // a presented instruction is consumed unless held by stall
        if_valid_d   = if_valid_q && stall_i;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if (redirect_valid_i) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            pc_d         = redirect_pc;
            state_d      = S_REQ;
            drop_d       = 1'b0;
            // a request granted now, or still awaiting data, belongs to the old path
            if ((state_q == S_REQ && imem.imem_gnt) || (state_q == S_WAIT && !imem.imem_rvalid)) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_REQ: if (imem.imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
                S_WAIT: if (imem.imem_rvalid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                    if (!drop_q && slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem.imem_rdata;
                    end else if (!drop_q) begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = req_pc_q;
                        skid_instr_d = imem.imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
                S_HOLD: if (!stall_i) begin
                    if_valid_d   = skid_valid_q;
                    if_pc_d      = skid_pc_q;
                    if_instr_d   = skid_instr_q;
                    skid_valid_d = 1'b0;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    state_d      = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            drop_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/stall/redirect/reset stimulus with a queue scoreboard of the expected instruction stream.
//   The driver plays instruction memory and the pipeline; on every flush it reloads the queue
//   with the sequential address stream from the new fetch target. The monitor pops one entry
//   for each instruction consumed by IF/ID and also checks hold, flush, reset and throughput rules.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk, rst, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem             (bus),
        .if_valid_o       (if_valid),
        .if_pc_o          (if_pc),
        .if_instr_o       (if_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned total = 0, bad = 0, consumed = 0;
    logic [31:0] exp_q[$];
    bit          pending, orphan, fast, rel;
    logic [31:0] pend_addr;
    int          pend_delay, k, rst_left;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        exp_q.push_back(a);
    endtask

    // driver: memory model, stall/redirect/reset stimulus, scoreboard loading
    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        pending = 0; orphan = 0; fast = 1; rel = 0; k = 0; rst_left = 3; pend_addr = '0; pend_delay = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rel = 0;
            k++;
            if (k == 24) fast = 0;
            if (rst) begin
                rst_left--;
                if (rst_left != 0) continue;
                rst = 1'b0;
                rel = 1;
                k = 0;
                restart(RST_PC);
            end else if (!fast && $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                rst_left = 2;
                exp_q.delete();
                stall = 1'b0;
                redirect_valid = 1'b0;
                bus.imem_gnt = 1'b0;
                bus.imem_rvalid = 1'b0;
                if (pending) orphan = 1;
                pending = 0;
                continue;
            end
            if (pending) begin
                chk("one_outstanding", {63'd0, bus.imem_req}, 64'd0);
                bus.imem_gnt = 1'($urandom_range(0, 1));
                if (pend_delay == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata = word_of(pend_addr);
                    pending = 0;
                end else begin
                    bus.imem_rvalid = 1'b0;
                    bus.imem_rdata = $urandom;
                    pend_delay--;
                end
            end else begin
                bus.imem_rvalid = orphan || (!fast && $urandom_range(0, 7) == 0);
                bus.imem_rdata = orphan ? word_of(pend_addr) : $urandom;
                orphan = 0;
                bus.imem_gnt = fast || $urandom_range(0, 3) != 0;
                if (bus.imem_req && bus.imem_gnt) begin
                    pending = 1;
                    pend_addr = bus.imem_addr;
                    pend_delay = fast ? 0 : int'($urandom_range(0, 2));
                end
            end
            stall = fast ? 1'b0 : (stall ? $urandom_range(0, 2) != 0 : $urandom_range(0, 3) == 0);
            redirect_valid = !fast && !rel && $urandom_range(0, 19) == 0;
            if (redirect_valid) begin
                redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom_range(0, 32'hFFF);
                restart({redirect_pc[31:2], 2'b00});
            end
            while (exp_q.size() > 0 && exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
        end
        chk("liveness_consumed_gt_150", {63'd0, consumed > 150}, 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // monitor: pops the scoreboard on every consumed instruction and checks output rules
    initial begin
        logic        pv, pst, prd, prst;
        logic [31:0] ppc, pin, e;
        pv = 0; pst = 0; prd = 0; prst = 1; ppc = '0; pin = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                chk("reset_outputs", {if_valid, if_pc, if_instr[30:0]}, 64'd0);
                chk("reset_req_addr", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, RST_PC});
            end else begin
                if (rel) chk("release_req_addr", {31'd0, bus.imem_req, bus.imem_addr}, {31'd0, 1'b1, RST_PC});
                if (fast) chk("throughput_pattern", {63'd0, if_valid}, {63'd0, k >= 2 && k % 2 == 0});
                if (prd && !prst) chk("redirect_flush", {63'd0, if_valid}, 64'd0);
                else if (pst && pv && !prst) chk("stall_hold", {if_valid, if_pc, if_instr[30:0]}, {pv, ppc, pin[30:0]});
                if (bus.imem_req) chk("addr_aligned", {62'd0, bus.imem_addr[1:0]}, 64'd0);
                if (if_valid && !stall && !redirect_valid) begin
                    consumed++;
                    if (exp_q.size() == 0) chk("unexpected_instr", {32'd0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        e = exp_q.pop_front();
                        chk("if_pc", {32'd0, if_pc}, {32'd0, e});
                        chk("if_instr", {32'd0, if_instr}, {32'd0, word_of(e)});
                    end
                end
            end
            pv = if_valid; ppc = if_pc; pin = if_instr;
            pst = stall; prd = redirect_valid; prst = rst;
        end
    end
endmodule
